fab_inject_port: RTL and testbench

- Transmit end of the tile-to-router allocation interface.
- Accepts transactions from a local tile source, computes the XY routing cardinal for each, buffers them in order, and pushes them into one input FIFO of a router fifo_arb.
- Drives the valid_alloc_req#/alloc_req# pair and obeys that FIFO's out_ready_fifo# (ready = not full).

---
 rtl/fab_inject_port.sv | 157 +++++++++++++++
 tb/tb_fab_inject_port.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fab_inject_port.sv
// rtl/fab_inject_port.sv - tile-side XY-routing injection buffer feeding a router fifo_arb input FIFO
// Optional watchdog on blocked pushes: `define FAB_INJECT_WATCHDOG_EN (assertion under SIM_ONLY).

package fab_inject_pkg;
    typedef enum logic [2:0] {
        CARD_LOCAL = 3'd0,
        CARD_NORTH = 3'd1,
        CARD_EAST  = 3'd2,
        CARD_SOUTH = 3'd3,
        CARD_WEST  = 3'd4
    } t_cardinal;

    typedef struct packed {
        logic [7:0]  src_tile_id;
        t_cardinal   next_tile_fifo_arb_id;
        logic [15:0] payload;
    } t_tile_trans;
endpackage

module fab_inject_port
    import fab_inject_pkg::*;
#(
    parameter int INJ_DEPTH = 4,
    parameter int TILE_ID_W = 8,
    parameter int WD_LIMIT  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  var t_tile_trans              in_req,
    input  logic [TILE_ID_W-1:0]         in_dest_tile_id,
    input  logic [TILE_ID_W-1:0]         local_tile_id,
    output logic                         valid_alloc_req,
    output var t_tile_trans              alloc_req,
    input  logic                         in_ready_fifo,
    output logic [$clog2(INJ_DEPTH):0]   occupancy,
    output logic                         wd_err
);
    localparam int PTR_W  = $clog2(INJ_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int HALF_W = TILE_ID_W / 2;

    if ((INJ_DEPTH < 2) || ((INJ_DEPTH & (INJ_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("INJ_DEPTH must be a power of 2 and at least 2");
    end
    if (WD_LIMIT < 1) begin : g_bad_wd_limit
        $error("WD_LIMIT must be at least 1");
    end

    // X-first dimension-order routing; X is the upper half of the tile id.
    function automatic t_cardinal route_xy(input logic [TILE_ID_W-1:0] dest,
                                           input logic [TILE_ID_W-1:0] here);
        logic [HALF_W-1:0] dx, dy, lx, ly;
        dx = dest[TILE_ID_W-1 -: HALF_W];
        dy = dest[HALF_W-1:0];
        lx = here[TILE_ID_W-1 -: HALF_W];
        ly = here[HALF_W-1:0];
        if (dx > lx)      return CARD_EAST;
        else if (dx < lx) return CARD_WEST;
        else if (dy > ly) return CARD_NORTH;
        else if (dy < ly) return CARD_SOUTH;
        else              return CARD_LOCAL;
    endfunction

    t_tile_trans        mem_q [INJ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   rd_sel;
    logic               empty, full, push_en, pop_en;
    t_tile_trans        enq_entry;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == OCC_W'(INJ_DEPTH));
    assign push_en = in_valid && !full;
    assign pop_en  = !empty && in_ready_fifo;

    assign in_ready        = !full;
    assign valid_alloc_req = pop_en;
    assign occupancy       = occ_q;

    // When empty, point at the most recently pushed slot so alloc_req holds its last value.
    assign rd_sel    = empty ? (rd_ptr_q - PTR_W'(1)) : rd_ptr_q;
    assign alloc_req = mem_q[rd_sel];

    always_comb begin
        enq_entry                       = in_req;
        enq_entry.next_tile_fifo_arb_id = route_xy(in_dest_tile_id, local_tile_id);
    end

    always_comb begin
        wr_ptr_d = push_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_en  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_en, pop_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < INJ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_en) begin
                mem_q[wr_ptr_q] <= enq_entry;
            end
        end
    end

`ifdef FAB_INJECT_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (empty || pop_en) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_W'(WD_LIMIT)) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_cnt_d == WD_W'(WD_LIMIT)) begin
                wd_err_q <= 1'b1;
            end
        end
    end

    assign wd_err = wd_err_q;

`ifdef SIM_ONLY
    wd_err_rise_a: assert property (@(posedge clk) disable iff (rst) !(wd_err_q && !$past(wd_err_q)))
        else $error("MAFIA_ASSERT: injection port blocked for %0d cycles", WD_LIMIT);
`endif
`else
    assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_fab_inject_port.sv
// tb/tb_fab_inject_port.sv - directed-vector bench for fab_inject_port with push scoreboard

module tb_fab_inject_port;
    import fab_inject_pkg::*;

    localparam int INJ_DEPTH = 4;
    localparam int TILE_ID_W = 8;
    localparam int WD_LIMIT  = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    t_tile_trans          in_req = '0;
    logic [TILE_ID_W-1:0] in_dest_tile_id = '0;
    logic [TILE_ID_W-1:0] local_tile_id = 8'h22;
    logic                 valid_alloc_req;
    t_tile_trans          alloc_req;
    logic                 in_ready_fifo = 1'b0;
    logic [2:0]           occupancy;
    logic                 wd_err;

    fab_inject_port #(
        .INJ_DEPTH (INJ_DEPTH),
        .TILE_ID_W (TILE_ID_W),
        .WD_LIMIT  (WD_LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_req          (in_req),
        .in_dest_tile_id (in_dest_tile_id),
        .local_tile_id   (local_tile_id),
        .valid_alloc_req (valid_alloc_req),
        .alloc_req       (alloc_req),
        .in_ready_fifo   (in_ready_fifo),
        .occupancy       (occupancy),
        .wd_err          (wd_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_mis = 0;
    int          viol  = 0;
    logic        toggle_mode = 1'b0;
    int unsigned last_acc_cyc = 0;
    t_tile_trans got_q[$];
    t_tile_trans exp_q[$];
    int unsigned got_cyc[$];

`ifdef FAB_INJECT_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_alloc_req) begin
            got_q.push_back(alloc_req);
            got_cyc.push_back(cyc);
            if (!in_ready_fifo) viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) in_ready_fifo = ~in_ready_fifo;
    endtask

    function automatic t_tile_trans mk(input logic [15:0] payload, input t_cardinal card);
        t_tile_trans t;
        t.src_tile_id           = 8'h22;
        t.next_tile_fifo_arb_id = card;
        t.payload               = payload;
        return t;
    endfunction

    // Drives one transaction with a junk cardinal field; the DUT must overwrite it.
    task automatic send_one(input logic [7:0] dest, input logic [15:0] payload, input t_cardinal card);
        bit done = 0;
        in_valid        = 1'b1;
        in_dest_tile_id = dest;
        in_req          = mk(payload, card);
        in_req.next_tile_fifo_arb_id = CARD_WEST;
        if (card == CARD_WEST) in_req.next_tile_fifo_arb_id = CARD_NORTH;
        for (int k = 0; k < 60 && !done; k++) begin
            if (in_ready) begin
                exp_q.push_back(mk(payload, card));
                last_acc_cyc = cyc;
                done = 1;
            end
            tick();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_sb(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_data"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        t_cardinal   cards [5];
        logic [7:0]  dests [5];
        int unsigned acc0;
        logic [19:0] rdy_hist;
        bit          spaced;

        cards = '{CARD_EAST, CARD_WEST, CARD_NORTH, CARD_SOUTH, CARD_LOCAL};
        dests = '{8'h42, 8'h02, 8'h25, 8'h21, 8'h22};

        // reset state
        tick(); tick();
        check("rst_occ", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", valid_alloc_req, 0);
        check("rst_alloc_req", alloc_req, 0);
        check("rst_wd_err", wd_err, 0);
        rst = 1'b0;
        tick();

        // XY routing, one push per cycle starting one cycle after first accept
        in_ready_fifo = 1'b1;
        acc0 = 0;
        for (int i = 0; i < 5; i++) begin
            send_one(dests[i], 16'h1000 + 16'(i), cards[i]);
            if (i == 0) acc0 = last_acc_cyc;
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("t1_push_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check("t1_cardinal", got_q[i].next_tile_fifo_arb_id, cards[i]);
            check("t1_push_cycle", got_cyc[i], acc0 + 1 + i);
        end
        compare_sb("t1");

        // fill while blocked, then release
        in_ready_fifo = 1'b0;
        for (int i = 0; i < 4; i++) send_one(8'h22, 16'h2000 + 16'(i), CARD_LOCAL);
        in_valid = 1'b0;
        check("t2_in_ready_full", in_ready, 0);
        check("t2_occ_full", occupancy, 4);
        tick(); tick();
        check("t2_no_push", got_q.size(), 0);
        in_ready_fifo = 1'b1;
        #1;
        check("t2_valid_on_release", valid_alloc_req, 1);
        check("t2_in_ready_same_cycle", in_ready, 0);
        tick();
        check("t2_in_ready_after_pop", in_ready, 1);
        check("t2_occ_after_pop", occupancy, 3);
        tick(); tick(); tick(); tick();
        check("t2_occ_drained", occupancy, 0);
        if (got_cyc.size() == 4) check("t2_consecutive", got_cyc[3] - got_cyc[0], 3);
        else check("t2_consecutive", got_cyc.size(), 4);
        compare_sb("t2");

        // sustained throughput from full
        in_ready_fifo = 1'b0;
        for (int i = 0; i < 4; i++) send_one(8'h22, 16'h3000 + 16'(i), CARD_LOCAL);
        in_ready_fifo = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid        = 1'b1;
            in_dest_tile_id = 8'h22;
            in_req          = mk(16'h3100 + 16'(k), CARD_LOCAL);
            rdy_hist[k]     = in_ready;
            if (in_ready) exp_q.push_back(mk(16'h3100 + 16'(k), CARD_LOCAL));
            tick();
        end
        in_valid = 1'b0;
        check("t3_ready_pattern", rdy_hist, 20'hFFFFE);
        check("t3_pushes_in_window", got_q.size(), 20);
        check("t3_occ_stable", occupancy, 3);
        tick(); tick(); tick(); tick();
        compare_sb("t3");

        // in_ready_fifo toggling every cycle
        viol = 0;
        in_ready_fifo = 1'b1;
        toggle_mode = 1'b1;
        for (int i = 0; i < 8; i++) send_one(8'h22, 16'h4000 + 16'(i), CARD_LOCAL);
        in_valid = 1'b0;
        for (int k = 0; k < 40 && occupancy != 0; k++) tick();
        toggle_mode = 1'b0;
        check("t4_drained", occupancy, 0);
        check("t4_push_while_blocked", viol, 0);
        spaced = 1;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] < 2) spaced = 0;
        check("t4_one_push_per_high", spaced, 1);
        compare_sb("t4");

        // reset with entries buffered
        in_ready_fifo = 1'b0;
        for (int i = 0; i < 3; i++) send_one(8'h22, 16'h5000 + 16'(i), CARD_LOCAL);
        in_valid = 1'b0;
        check("t5_occ_before", occupancy, 3);
        in_ready_fifo = 1'b1;
        rst = 1'b1;
        #1;
        check("t5_valid_in_reset", valid_alloc_req, 0);
        check("t5_occ_in_reset", occupancy, 0);
        check("t5_in_ready_in_reset", in_ready, 1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        send_one(8'h22, 16'hBEEF, CARD_LOCAL);
        in_valid = 1'b0;
        tick(); tick(); tick();
        compare_sb("t5");

        // watchdog (or its absence)
        in_ready_fifo = 1'b0;
        send_one(8'h22, 16'h6000, CARD_LOCAL);
        in_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("t6_wd_before_limit", wd_err, 0);
        tick();
        check("t6_wd_at_limit", wd_err, WD_EXP);
        in_ready_fifo = 1'b1;
        tick(); tick();
        check("t6_wd_sticky", wd_err, WD_EXP);
        compare_sb("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
